// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, PC redirect input and the
// valid/stall channel towards the decoder.
interface instruction_fetch_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [15:0]         imem_rdata;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                id_stall;
  logic                if_valid;
  logic [15:0]         if_instruction;
  logic [PC_WIDTH-1:0] if_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc, id_stall,
    output if_valid, if_instruction, if_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc, id_stall,
    input  if_valid, if_instruction, if_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// microRISC fetch stage: PC, single-outstanding instruction fetch, one-entry skid
// buffer in front of the decoder, and redirect/flush of wrong-path fetches.
module instruction_fetch #(
  parameter int unsigned         PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus_io
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                run_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                discard_q, discard_d;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic [15:0]         skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

  logic req_s;
  logic grant_s;
  logic resp_s;
  logic keep_s;
  logic out_xfer_s;
  logic redirect_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: redirects never change the transition, only what happens to the data
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (grant_s) state_d = S_WAIT;
        else         state_d = S_REQ;
      end
      S_WAIT: begin
        if (bus_io.imem_rvalid) state_d = S_REQ;
        else                    state_d = S_WAIT;
      end
      default: state_d = S_REQ;
    endcase
  end

  // FSM outputs: request only after reset release and while the skid buffer is empty
  always_comb begin
    req_s = 1'b0;
    case (state_q)
      S_REQ:   req_s = run_q & ~skid_valid_q;
      S_WAIT:  req_s = 1'b0;
      default: req_s = 1'b0;
    endcase
  end

  // Handshake events of the current cycle
  always_comb begin
    redirect_s = bus_io.redirect_valid;
    grant_s    = req_s & bus_io.imem_gnt;
    resp_s     = (state_q == S_WAIT) & bus_io.imem_rvalid;
    keep_s     = resp_s & ~discard_q & ~redirect_s;
    out_xfer_s = out_valid_q & ~bus_io.id_stall;
  end

  // PC, outstanding-request address and wrong-path discard flag
  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    if (grant_s) begin
      req_pc_d = pc_q;
    end else begin
      req_pc_d = req_pc_q;
    end
    if (redirect_s) begin
      pc_d      = bus_io.redirect_pc;
      // A response still in flight after this cycle belongs to the old path.
      discard_d = grant_s | ((state_q == S_WAIT) & ~bus_io.imem_rvalid);
    end else if (grant_s) begin
      pc_d      = pc_q + PC_ONE;
      discard_d = discard_q;
    end else if (resp_s) begin
      pc_d      = pc_q;
      discard_d = 1'b0;
    end else begin
      pc_d      = pc_q;
      discard_d = discard_q;
    end
  end

  // Output register and skid buffer; a stalled output is never overwritten
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (redirect_s) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (keep_s) begin
      if (~out_valid_q | out_xfer_s) begin
        out_valid_d = 1'b1;
        out_instr_d = bus_io.imem_rdata;
        out_pc_d    = req_pc_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = bus_io.imem_rdata;
        skid_pc_d    = req_pc_q;
      end
    end else if (out_xfer_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q        <= 1'b0;
      pc_q         <= RESET_PC;
      req_pc_q     <= {PC_WIDTH{1'b0}};
      discard_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= 16'h0000;
      out_pc_q     <= {PC_WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc_q    <= {PC_WIDTH{1'b0}};
    end else begin
      run_q        <= 1'b1;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      discard_q    <= discard_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign bus_io.imem_req       = req_s;
  assign bus_io.imem_addr      = pc_q;
  assign bus_io.if_valid       = out_valid_q;
  assign bus_io.if_instruction = out_instr_q;
  assign bus_io.if_pc          = out_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch; a transaction-level model
// tracks the expected fetch address and the expected in-order delivery stream.
module tb_instruction_fetch;
  localparam int unsigned PW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if #(.PC_WIDTH(PW)) bus  ();
  instruction_fetch_if #(.PC_WIDTH(PW)) bus2 ();

  instruction_fetch #(.PC_WIDTH(PW), .RESET_PC(16'h0000)) dut  (.clk(clk), .rst(rst), .bus_io(bus));
  instruction_fetch #(.PC_WIDTH(PW), .RESET_PC(16'hFFFF)) dut2 (.clk(clk), .rst(rst), .bus_io(bus2));

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_xfer  = 0;
  int          gnt_pct = 100;
  int          lat_max = 0;
  bit          hold_rv = 1'b0;
  bit          stall_v = 1'b0;
  bit          redir_v = 1'b0;
  logic [15:0] redir_pc_v = 16'h0000;

  bit          mem_busy = 1'b0;
  logic [15:0] mem_pend = 16'h0000;
  int          mem_cnt  = 0;
  bit          busy2    = 1'b0;
  logic [15:0] pend2    = 16'h0000;

  logic [15:0] exp_fetch  = 16'h0000;
  logic [15:0] exp_pc     = 16'h0000;
  bit          prev_hold  = 1'b0;
  bit          prev_redir = 1'b0;
  logic [15:0] prev_pc    = 16'h0000;
  logic [15:0] prev_instr = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h0298;
      16'h0001: return 16'h1685;
      16'h0002: return 16'h4284;
      default:  return (a * 16'h9E37) ^ 16'h5A5A ^ {a[7:0], a[15:8]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory/control at the falling edge, check the model, advance.
  task automatic tick();
    bit          rv;
    bit          g;
    bit          g2;
    bit          rv2;
    logic [15:0] gaddr;
    logic [15:0] gaddr2;
    bus.id_stall       = stall_v;
    bus.redirect_valid = redir_v;
    bus.redirect_pc    = redir_pc_v;
    bus.imem_gnt       = bus.imem_req && !mem_busy && (int'($urandom_range(99)) < gnt_pct);
    rv                 = mem_busy && (mem_cnt == 0) && !hold_rv;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? mem_word(mem_pend) : 16'($urandom);
    bus2.imem_gnt      = bus2.imem_req && !busy2;
    bus2.imem_rvalid   = busy2;
    bus2.imem_rdata    = busy2 ? mem_word(pend2) : 16'h0000;
    g      = bus.imem_req && bus.imem_gnt;
    gaddr  = bus.imem_addr;
    g2     = bus2.imem_req && bus2.imem_gnt;
    gaddr2 = bus2.imem_addr;
    rv2    = busy2;
    if (rst) begin
      exp_fetch  = 16'h0000;
      exp_pc     = 16'h0000;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.if_valid), 32'd1);
        chk("hold_pc",    32'(bus.if_pc), 32'(prev_pc));
        chk("hold_instr", 32'(bus.if_instruction), 32'(prev_instr));
      end
      if (prev_redir) chk("flush_valid", 32'(bus.if_valid), 32'd0);
      if (g) chk("fetch_addr", 32'(gaddr), 32'(exp_fetch));
      if (!redir_v && bus.if_valid && !stall_v) begin
        chk("xfer_pc",    32'(bus.if_pc), 32'(exp_pc));
        chk("xfer_instr", 32'(bus.if_instruction), 32'(mem_word(exp_pc)));
        exp_pc = exp_pc + 16'h0001;
        n_xfer++;
      end
      prev_hold  = bus.if_valid && stall_v && !redir_v;
      prev_pc    = bus.if_pc;
      prev_instr = bus.if_instruction;
      prev_redir = redir_v;
      if (g) exp_fetch = exp_fetch + 16'h0001;
      if (redir_v) begin
        exp_fetch = redir_pc_v;
        exp_pc    = redir_pc_v;
      end
    end
    @(posedge clk);
    if (rv) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0 && !hold_rv) mem_cnt--;
    if (g) begin
      mem_busy = 1'b1;
      mem_pend = gaddr;
      mem_cnt  = int'($urandom_range(lat_max));
    end
    if (rv2 || rst) busy2 = 1'b0;
    if (g2 && !rst) begin
      busy2 = 1'b1;
      pend2 = gaddr2;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    stall_v = 1'b0;
    redir_v = 1'b0;
    hold_rv = 1'b0;
    tick();
    tick();
    mem_busy = 1'b0;
    mem_cnt  = 0;
    rst      = 1'b0;
  endtask

  initial begin : stim
    logic [15:0] seq_exp  [3];
    logic [15:0] wrap_exp [3];
    bit          found;
    int          k;
    seq_exp  = '{16'h0298, 16'h1685, 16'h4284};
    wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001};
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 16'h0000;
    bus2.id_stall       = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_instr", 32'(bus.if_instruction), 32'd0);
    chk("rst_pc",    32'(bus.if_pc), 32'd0);
    mem_busy = 1'b0;
    rst      = 1'b0;

    // Sequential fetch with a 1-cycle memory; the RESET_PC=FFFF instance wraps
    gnt_pct = 100;
    lat_max = 0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1) chk("req_after_rst", 32'(bus.imem_req), 32'd1);
      if (t >= 3 && (t % 2) == 1) begin
        k = (t - 3) / 2;
        chk("seq_valid", 32'(bus.if_valid), 32'd1);
        chk("seq_pc",    32'(bus.if_pc), 32'(k));
        chk("seq_instr", 32'(bus.if_instruction), 32'(seq_exp[k]));
        chk("wrap_valid", 32'(bus2.if_valid), 32'd1);
        chk("wrap_pc",    32'(bus2.if_pc), 32'(wrap_exp[k]));
      end else begin
        chk("seq_gap", 32'(bus.if_valid), 32'd0);
      end
    end

    // Stall fills the skid buffer and blocks requests; release drains it
    do_reset();
    stall_v = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t >= 6) begin
        chk("stall_valid", 32'(bus.if_valid), 32'd1);
        chk("stall_pc",    32'(bus.if_pc), 32'd0);
        chk("stall_req",   32'(bus.imem_req), 32'd0);
      end
    end
    stall_v = 1'b0;
    tick();
    chk("skid_valid", 32'(bus.if_valid), 32'd1);
    chk("skid_pc",    32'(bus.if_pc), 32'd1);
    chk("skid_instr", 32'(bus.if_instruction), 32'(seq_exp[1]));
    chk("resume_req", 32'(bus.imem_req), 32'd1);
    chk("resume_addr", 32'(bus.imem_addr), 32'd2);

    // Redirect while waiting: the wrong-path word for address 5 is dropped
    do_reset();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (bus.imem_req && bus.imem_addr == 16'h0005) found = 1'b1;
      else tick();
    end
    chk("reach_addr5", 32'(found), 32'd1);
    hold_rv = 1'b1;
    tick();
    redir_v    = 1'b1;
    redir_pc_v = 16'h0100;
    tick();
    redir_v = 1'b0;
    hold_rv = 1'b0;
    found   = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (bus.if_valid) found = 1'b1;
    end
    chk("redir_wait_seen",  32'(found), 32'd1);
    chk("redir_wait_pc",    32'(bus.if_pc), 32'h0100);
    chk("redir_wait_instr", 32'(bus.if_instruction), 32'(mem_word(16'h0100)));

    // Redirect in the same cycle as the response: no extra word dropped
    do_reset();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (bus.imem_req && bus.imem_addr == 16'h0003) found = 1'b1;
      else tick();
    end
    chk("reach_addr3", 32'(found), 32'd1);
    tick();
    redir_v    = 1'b1;
    redir_pc_v = 16'h0200;
    tick();
    redir_v = 1'b0;
    chk("redir_rv_req",   32'(bus.imem_req), 32'd1);
    chk("redir_rv_addr",  32'(bus.imem_addr), 32'h0200);
    chk("redir_rv_flush", 32'(bus.if_valid), 32'd0);
    tick();
    tick();
    chk("redir_rv_valid", 32'(bus.if_valid), 32'd1);
    chk("redir_rv_pc",    32'(bus.if_pc), 32'h0200);
    chk("redir_rv_instr", 32'(bus.if_instruction), 32'(mem_word(16'h0200)));

    // Asynchronous reset between grant and response; the late response is ignored
    do_reset();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (bus.imem_req && bus.imem_addr == 16'h0004) found = 1'b1;
      else tick();
    end
    chk("reach_addr4", 32'(found), 32'd1);
    hold_rv = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_req",   32'(bus.imem_req), 32'd0);
    chk("arst_valid", 32'(bus.if_valid), 32'd0);
    chk("arst_instr", 32'(bus.if_instruction), 32'd0);
    chk("arst_pc",    32'(bus.if_pc), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    hold_rv = 1'b0;
    found   = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (bus.if_valid) found = 1'b1;
    end
    chk("arst_restart_seen",  32'(found), 32'd1);
    chk("arst_restart_pc",    32'(bus.if_pc), 32'd0);
    chk("arst_restart_instr", 32'(bus.if_instruction), 32'(seq_exp[0]));

    // Randomized traffic: grant gaps, variable latency, stalls and redirects
    do_reset();
    gnt_pct = 70;
    lat_max = 3;
    n_xfer  = 0;
    for (int i = 0; i < 3000; i++) begin
      stall_v    = (int'($urandom_range(99)) < 30);
      redir_v    = (int'($urandom_range(99)) < 5);
      redir_pc_v = ($urandom_range(3) == 0) ? 16'hFFFE : 16'($urandom);
      tick();
    end
    redir_v = 1'b0;
    stall_v = 1'b0;
    chk("liveness", 32'(n_xfer > 150), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the microRISC core. Sits directly upstream of instruction_decoder: keeps the PC, fetches 16-bit instruction words from instruction memory over a request/grant/response handshake, and presents them with their PC to the decoder through a valid/stall interface. It accepts PC redirects from branch/jump resolution and flushes any wrong-path fetch.

Parameters:
PC_WIDTH, 16, PC and instruction-memory word-address width (word addressed, one 16-bit instruction per address).
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request valid.
imem_addr  output  PC_WIDTH  word address of the request.
imem_gnt  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  response data valid; at least 1 cycle after grant.
imem_rdata  input  16  instruction word.
redirect_valid  input  1  load the PC with redirect_pc and flush.
redirect_pc  input  PC_WIDTH  redirect target.
id_stall  input  1  decoder cannot accept this cycle.
if_valid  output  1  if_instruction/if_pc hold a valid instruction.
if_instruction  output  16  instruction to the decoder.
if_pc  output  PC_WIDTH  address of if_instruction.

Behaviour:
- Reset (async): pc=RESET_PC, state=S_REQ, if_valid=0, if_instruction=16'h0000, if_pc=0, skid empty, discard=0, imem_req=0 during reset. imem_req=1 from the first cycle after rst deasserts.
- Exactly one request outstanding. Transfer to the decoder: if_valid & !id_stall.
- S_REQ: imem_req=1 while the skid buffer is empty, else 0. imem_addr=pc. When imem_req & imem_gnt: pc<=pc+1 (wraps 16'hFFFF->16'h0000), go to S_WAIT.
- S_WAIT: imem_req=0. On imem_rvalid, go to S_REQ. If discard=1, drop the data and clear discard. Otherwise:
  - If the output register is empty or transfers this cycle, load it: if_valid=1, if_instruction=imem_rdata, if_pc=address of that request.
  - Else write the skid buffer (instruction plus its PC).
- Skid buffer drains into the output register on the cycle the output transfers. Output is never overwritten while if_valid & id_stall.
- Best-case throughput is 1 instruction per 2 cycles (grant, then response). Latency from request to if_valid is the memory latency plus 1 cycle.
- Redirect (redirect_valid=1) has priority over every other event that cycle:
  - pc<=redirect_pc; if_valid<=0; skid cleared.
  - If in S_WAIT with no rvalid this cycle, or in S_REQ with gnt this cycle: discard<=1. Exactly one later response is dropped.
  - If in S_WAIT with rvalid this cycle: that response is dropped, discard stays 0, next state S_REQ.
  - In S_REQ without gnt: the next cycle's imem_addr is redirect_pc. The memory must tolerate an ungranted request changing address.
  - Redirect while id_stall=1 still flushes.
- Reset mid-transaction: every register returns to its reset value. A response arriving later is ignored, because the state is S_REQ and the response is only sampled in S_WAIT.
- imem_rvalid while in S_REQ is ignored.

Test Plan:
- Sequential fetch, 1-cycle memory, id_stall=0: mem[0..2]=16'h0298,16'h1685,16'h4284 -> if_valid pulses with if_pc 0,1,2 carrying those words, one every 2 cycles; the first is valid 3 cycles after rst deasserts.
- Stall and skid: hold id_stall=1 with if_pc=0 valid -> word 1 goes to the skid buffer and imem_req stays 0. Release the stall -> if_pc=1 is valid the next cycle, then fetch resumes at addr 2.
- Redirect during S_WAIT: grant addr 5, assert redirect_valid with redirect_pc=16'h0100 before rvalid -> addr 5's data never appears on if_*. The next if_pc is 16'h0100 with mem[16'h0100].
- Redirect and rvalid in the same cycle -> the response is dropped, discard=0, the next request is at the redirect target, and no extra response is dropped.
- PC wrap: RESET_PC=16'hFFFF -> if_pc sequence is FFFF, 0000, 0001.
- Async reset mid-fetch: assert rst between grant and rvalid -> all outputs go to reset values immediately. The late rvalid is ignored, and fetch restarts at RESET_PC.
